// File: rtl/fe_branch_predictor.sv
// fe_branch_predictor: gshare direction predictor with direct-mapped BTB and saturating mispredict counter
module fe_branch_predictor #(
    parameter int DBITS        = 32,
    parameter int BHR_BITS     = 8,
    parameter int BTB_IDX_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DBITS-1:0]    pc_i,
    output logic                pred_taken_o,
    output logic [DBITS-1:0]    pred_target_o,
    output logic                btb_hit_o,
    output logic [BHR_BITS-1:0] bhr_o,
    input  logic                upd_valid_i,
    input  logic [DBITS-1:0]    upd_pc_i,
    input  logic [BHR_BITS-1:0] upd_bhr_i,
    input  logic                upd_taken_i,
    input  logic [DBITS-1:0]    upd_target_i,
    input  logic                upd_mispred_i,
    output logic [DBITS-1:0]    mispred_cnt_o
);
    localparam int PHT_N = 1 << BHR_BITS;
    localparam int BTB_N = 1 << BTB_IDX_BITS;
    localparam int TAG_W = DBITS - BTB_IDX_BITS - 2;

    logic [1:0]              pht_q [PHT_N];
    logic [BTB_N-1:0]        valid_q;
    logic [TAG_W-1:0]        tag_q [BTB_N];
    logic [DBITS-1:0]        tgt_q [BTB_N];
    logic [BHR_BITS-1:0]     bhr_q, bhr_d;
    logic [DBITS-1:0]        cnt_q, cnt_d;
    logic [BHR_BITS-1:0]     pht_idx, upd_pht_idx;
    logic [BTB_IDX_BITS-1:0] btb_idx, upd_btb_idx;
    logic [1:0]              ctr, ctr_d;
    logic                    unused_ok;

    assign unused_ok     = ^{pc_i[1:0], upd_pc_i[1:0]};
    assign bhr_o         = bhr_q;
    assign mispred_cnt_o = cnt_q;

    always_comb begin
        pht_idx       = pc_i[BHR_BITS+1:2] ^ bhr_q;
        btb_idx       = pc_i[BTB_IDX_BITS+1:2];
        btb_hit_o     = valid_q[btb_idx] && (tag_q[btb_idx] == pc_i[DBITS-1:BTB_IDX_BITS+2]);
        pred_taken_o  = btb_hit_o && pht_q[pht_idx][1];
        pred_target_o = pred_taken_o ? tgt_q[btb_idx] : pc_i + DBITS'(4);
    end

    // History is rebuilt from the resolving branch's snapshot, which also repairs it after a mispredict
    always_comb begin
        upd_pht_idx = upd_pc_i[BHR_BITS+1:2] ^ upd_bhr_i;
        upd_btb_idx = upd_pc_i[BTB_IDX_BITS+1:2];
        ctr         = pht_q[upd_pht_idx];
        ctr_d       = upd_taken_i ? (ctr == 2'd3 ? ctr : ctr + 2'd1) : (ctr == 2'd0 ? ctr : ctr - 2'd1);
        bhr_d       = upd_valid_i ? {upd_bhr_i[BHR_BITS-2:0], upd_taken_i} : bhr_q;
        cnt_d       = (upd_valid_i && upd_mispred_i && !(&cnt_q)) ? cnt_q + DBITS'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'b01;
            for (int i = 0; i < BTB_N; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
            end
            valid_q <= '0;
            bhr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            bhr_q <= bhr_d;
            cnt_q <= cnt_d;
            if (upd_valid_i) begin
                pht_q[upd_pht_idx] <= ctr_d;
                if (upd_taken_i) begin
                    valid_q[upd_btb_idx] <= 1'b1;
                    tag_q[upd_btb_idx]   <= upd_pc_i[DBITS-1:BTB_IDX_BITS+2];
                    tgt_q[upd_btb_idx]   <= upd_target_i;
                end
            end
        end
    end
endmodule
